// File: rtl/hyperbus_ck_seq.sv
// hyperbus_ck_seq
//   Transaction sequencer feeding the HyperBus CK gating / differential output
//   stage. For each accepted request it pulls CS# low, waits a setup time,
//   enables CK for exactly N cycles, holds CS# low, then releases CS# and
//   enforces a CS# high recovery time before the next request is accepted.
//
// Ports
//   clk_i          PHY clock (same clock as the diff-out stage)
//   rst_i          asynchronous reset, active-high
//   req_valid_i    request valid
//   req_ready_o    request ready, high only in IDLE (combinational from state)
//   req_ncycles_i  number of CK-enabled cycles, sampled on accept
//   abort_i        end the current burst early (honoured in SETUP / ACTIVE)
//   cs_no          chip select, active-low, registered
//   ck_en_o        CK enable to the diff-out stage, registered
//   cyc_last_o     high during the final CK-enabled cycle
//   busy_o         high whenever not in IDLE, registered
//   done_o         one-cycle pulse in the first CS#-high cycle after HOLD
//   aborted_o      qualifies done_o; 1 when fewer than N CK cycles were sent
//
// State  | meaning
// -------+-------------------------------------------------------------
// IDLE   | CS# high, ready for a request
// SETUP  | CS# low, CK off, CS_SETUP cycles
// ACTIVE | CS# low, CK on, one cycle per remaining count
// HOLD   | CS# low, CK off, CS_HOLD cycles
// RECOVER| CS# high, not ready, CS_RECOVER cycles

module hyperbus_ck_seq #(
  parameter int CNT_W      = 16,
  parameter int CS_SETUP   = 2,
  parameter int CS_HOLD    = 1,
  parameter int CS_RECOVER = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [CNT_W-1:0] req_ncycles_i,
  input  logic             abort_i,
  output logic             cs_no,
  output logic             ck_en_o,
  output logic             cyc_last_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             aborted_o
);

  // Phase timer is shared by SETUP, HOLD and RECOVER; it only ever holds
  // (length - 1), so it is sized for the largest of the three.
  localparam int TMAX_SH = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
  localparam int TMAX    = (TMAX_SH > CS_RECOVER) ? TMAX_SH : CS_RECOVER;
  localparam int TMR_W   = (TMAX > 1) ? $clog2(TMAX) : 1;

  localparam logic [TMR_W-1:0] SETUP_LD = TMR_W'(CS_SETUP - 1);
  localparam logic [TMR_W-1:0] HOLD_LD  = TMR_W'(CS_HOLD - 1);
  localparam logic [TMR_W-1:0] REC_LD   = (CS_RECOVER > 0) ? TMR_W'(CS_RECOVER - 1) : '0;

  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETUP   = 3'd1,
    ST_ACTIVE  = 3'd2,
    ST_HOLD    = 3'd3,
    ST_RECOVER = 3'd4
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_n;
  logic [CNT_W-1:0] w_n_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [TMR_W-1:0] r_tmr;
  logic [TMR_W-1:0] w_tmr_nxt;
  logic             r_abt;
  logic             w_abt_nxt;

  logic             r_cs_n;
  logic             r_ck_en;
  logic             r_busy;
  logic             r_done;
  logic             r_aborted;

  logic             w_tmr_zero;
  logic             w_cnt_last;
  logic             w_hold_exit;
  logic             w_cs_low_nxt;

  assign w_tmr_zero  = (r_tmr == '0);
  assign w_cnt_last  = (r_cnt == CNT_ONE);
  assign w_hold_exit = (r_state == ST_HOLD) && w_tmr_zero;

  always_comb begin
    w_state_nxt = r_state;
    w_n_nxt     = r_n;
    w_cnt_nxt   = r_cnt;
    w_tmr_nxt   = r_tmr;
    w_abt_nxt   = r_abt;

    unique case (r_state)
      ST_IDLE: begin
        if (req_valid_i) begin
          w_state_nxt = ST_SETUP;
          w_n_nxt     = req_ncycles_i;
          w_tmr_nxt   = SETUP_LD;
          w_abt_nxt   = 1'b0;
        end
      end

      ST_SETUP: begin
        if (abort_i) begin
          // A zero-length burst loses nothing, so it is not reported as aborted.
          w_state_nxt = ST_HOLD;
          w_tmr_nxt   = HOLD_LD;
          w_abt_nxt   = (r_n != '0);
        end else if (w_tmr_zero) begin
          if (r_n != '0) begin
            w_state_nxt = ST_ACTIVE;
            w_cnt_nxt   = r_n;
          end else begin
            w_state_nxt = ST_HOLD;
            w_tmr_nxt   = HOLD_LD;
          end
        end else begin
          w_tmr_nxt = r_tmr - 1'b1;
        end
      end

      ST_ACTIVE: begin
        // The counter stops at 1 and is never decremented past it, so a
        // full-scale N cannot wrap.
        if (abort_i || w_cnt_last) begin
          w_state_nxt = ST_HOLD;
          w_tmr_nxt   = HOLD_LD;
          w_abt_nxt   = abort_i && !w_cnt_last;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end

      ST_HOLD: begin
        if (w_tmr_zero) begin
          if (CS_RECOVER > 0) begin
            w_state_nxt = ST_RECOVER;
            w_tmr_nxt   = REC_LD;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end else begin
          w_tmr_nxt = r_tmr - 1'b1;
        end
      end

      ST_RECOVER: begin
        if (w_tmr_zero) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_tmr_nxt = r_tmr - 1'b1;
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign w_cs_low_nxt = (w_state_nxt == ST_SETUP) ||
                        (w_state_nxt == ST_ACTIVE) ||
                        (w_state_nxt == ST_HOLD);

  // Pin outputs are registered from the next state so that they line up
  // exactly with the state they describe, with no decode glitches at the PHY.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state   <= ST_IDLE;
      r_n       <= '0;
      r_cnt     <= '0;
      r_tmr     <= '0;
      r_abt     <= 1'b0;
      r_cs_n    <= 1'b1;
      r_ck_en   <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_aborted <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_n       <= w_n_nxt;
      r_cnt     <= w_cnt_nxt;
      r_tmr     <= w_tmr_nxt;
      r_abt     <= w_abt_nxt;
      r_cs_n    <= !w_cs_low_nxt;
      r_ck_en   <= (w_state_nxt == ST_ACTIVE);
      r_busy    <= (w_state_nxt != ST_IDLE);
      r_done    <= w_hold_exit;
      r_aborted <= w_hold_exit && r_abt;
    end
  end

  assign req_ready_o = (r_state == ST_IDLE);
  assign cyc_last_o  = (r_state == ST_ACTIVE) && w_cnt_last;
  assign cs_no       = r_cs_n;
  assign ck_en_o     = r_ck_en;
  assign busy_o      = r_busy;
  assign done_o      = r_done;
  assign aborted_o   = r_aborted;

endmodule

// File: tb/tb_hyperbus_ck_seq.sv
module tb_hyperbus_ck_seq;

  localparam int S     = 2;
  localparam int H     = 1;
  localparam int R     = 2;
  localparam int DEPTH = 2048;
  localparam int NLIT  = 64;

  // expected vector layout: {ready, busy, cs_n, ck_en, last, done, aborted}
  localparam int B_RDY  = 6;
  localparam int B_BUSY = 5;
  localparam int B_CS   = 4;
  localparam int B_CK   = 3;
  localparam int B_LAST = 2;
  localparam int B_DONE = 1;
  localparam int B_ABT  = 0;
  localparam logic [6:0] IDLE_V = 7'b1010000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        v0 = 1'b0, ab0 = 1'b0;
  logic [15:0] n0 = '0;
  logic        rdy0, cs0, ck0, last0, busy0, done0, abt0;

  logic        v1 = 1'b0, ab1 = 1'b0;
  logic [3:0]  n1 = '0;
  logic        rdy1, cs1, ck1, last1, busy1, done1, abt1;

  hyperbus_ck_seq dut (
    .clk_i(clk), .rst_i(rst), .req_valid_i(v0), .req_ready_o(rdy0),
    .req_ncycles_i(n0), .abort_i(ab0), .cs_no(cs0), .ck_en_o(ck0),
    .cyc_last_o(last0), .busy_o(busy0), .done_o(done0), .aborted_o(abt0)
  );

  hyperbus_ck_seq #(.CNT_W(4)) dut4 (
    .clk_i(clk), .rst_i(rst), .req_valid_i(v1), .req_ready_o(rdy1),
    .req_ncycles_i(n1), .abort_i(ab1), .cs_no(cs1), .ck_en_o(ck1),
    .cyc_last_o(last1), .busy_o(busy1), .done_o(done1), .aborted_o(abt1)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [6:0] exp_v [2][DEPTH];
  bit         ck_hist [2][DEPTH];
  int         m_free [2];
  int         n_checks = 0;
  int         n_err = 0;

  typedef struct {
    int    u;
    int    c;
    int    kind;   // 0: single output bit at cycle c, 1: CK-enabled cycles in [lo, c]
    int    lo;
    int    fld;
    int    val;
    string nm;
  } lit_t;
  lit_t lit [NLIT];
  bit   lit_done [NLIT];
  int   lit_n = 0;

  // Model: a transaction accepted into cycle a is a fixed timeline of
  // setup / CK / hold / recover phases; an abort shortens setup or CK phase.
  // Returns the first idle cycle afterwards.
  function automatic int fill(input int u, input int a, input int n, input int r);
    int sl, d;
    bit ab;
    logic [6:0] v;
    if (r >= 1 && r <= S) begin
      sl = r; d = 0; ab = (n > 0);
    end else if (r > S && r <= S + n) begin
      sl = S; d = r - S; ab = (d < n);
    end else begin
      sl = S; d = n; ab = 1'b0;
    end
    for (int i = 0; i < sl + d + H + R; i++) begin
      v = '0;
      v[B_BUSY] = 1'b1;
      v[B_CS]   = (i >= sl + d + H);
      v[B_CK]   = (i >= sl && i < sl + d);
      v[B_LAST] = (d == n && n > 0 && i == sl + n - 1);
      if (a + i < DEPTH) exp_v[u][a + i] = v;
    end
    if (a + sl + d + H < DEPTH) begin
      exp_v[u][a + sl + d + H][B_DONE] = 1'b1;
      exp_v[u][a + sl + d + H][B_ABT]  = ab;
    end
    return a + sl + d + H + R;
  endfunction

  task automatic wait_to(input int k);
    while (cyc < k) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_req(input int u, input int n, input int r, output int a);
    int c;
    c = cyc;
    if (u == 0) begin v0 = 1'b1; n0 = 16'(n); end
    else        begin v1 = 1'b1; n1 = 4'(n); end
    a = ((c > m_free[u]) ? c : m_free[u]) + 1;
    m_free[u] = fill(u, a, n, r);
    wait_to(a);
    if (u == 0) v0 = 1'b0; else v1 = 1'b0;
  endtask

  task automatic pulse_abort(input int u, input int a, input int r);
    wait_to(a + r - 1);
    if (u == 0) ab0 = 1'b1; else ab1 = 1'b1;
    wait_to(a + r);
    if (u == 0) ab0 = 1'b0; else ab1 = 1'b0;
  endtask

  task automatic lb(input int u, input int c, input int fld, input int val, input string nm);
    if (lit_n < NLIT) begin
      lit[lit_n] = '{u, c, 0, 0, fld, val, nm};
      lit_n++;
    end
  endtask

  task automatic lc(input int u, input int lo, input int hi, input int val, input string nm);
    if (lit_n < NLIT) begin
      lit[lit_n] = '{u, hi, 1, lo, 0, val, nm};
      lit_n++;
    end
  endtask

  // Single compare process: model vector every cycle, invariant, literals.
  initial begin
    logic [6:0] act [2];
    int s;
    forever begin
      @(negedge clk);
      act[0] = {rdy0, busy0, cs0, ck0, last0, done0, abt0};
      act[1] = {rdy1, busy1, cs1, ck1, last1, done1, abt1};
      if (cyc < DEPTH) begin
        for (int u = 0; u < 2; u++) begin
          ck_hist[u][cyc] = act[u][B_CK];
          n_checks++;
          if (act[u] !== exp_v[u][cyc]) begin
            n_err++;
            $display("FAIL outputs inst%0d cyc%0d: got rdy/busy/cs_n/ck/last/done/abt=%b expected %b",
                     u, cyc, act[u], exp_v[u][cyc]);
          end
          n_checks++;
          if (act[u][B_CK] === 1'b1 && act[u][B_CS] !== 1'b0) begin
            n_err++;
            $display("FAIL ck_implies_cs inst%0d cyc%0d: got ck_en=1 cs_n=%b expected cs_n=0",
                     u, cyc, act[u][B_CS]);
          end
        end
        for (int i = 0; i < lit_n; i++) begin
          if (!lit_done[i] && lit[i].c == cyc) begin
            lit_done[i] = 1'b1;
            n_checks++;
            if (lit[i].kind == 0) begin
              if (int'(act[lit[i].u][lit[i].fld]) != lit[i].val) begin
                n_err++;
                $display("FAIL %s inst%0d cyc%0d: got %0d expected %0d",
                         lit[i].nm, lit[i].u, cyc, act[lit[i].u][lit[i].fld], lit[i].val);
              end
            end else begin
              s = 0;
              for (int k = lit[i].lo; k <= cyc; k++) s += int'(ck_hist[lit[i].u][k]);
              if (s != lit[i].val) begin
                n_err++;
                $display("FAIL %s inst%0d cyc%0d: got %0d ck cycles expected %0d",
                         lit[i].nm, lit[i].u, cyc, s, lit[i].val);
              end
            end
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cyc %0d", cyc);
    $fatal(1, "time limit");
  end

  initial begin
    int a, a1, a2, a3, a4, x;
    for (int u = 0; u < 2; u++)
      for (int c = 0; c < DEPTH; c++) exp_v[u][c] = IDLE_V;
    m_free[0] = 3;
    m_free[1] = 3;

    lb(0, 1, B_CS,   1, "reset_cs_n");
    lb(0, 1, B_CK,   0, "reset_ck_en");
    lb(0, 1, B_BUSY, 0, "reset_busy");
    lb(0, 1, B_DONE, 0, "reset_done");

    wait_to(3);
    rst = 1'b0;

    // N = 4, defaults
    do_req(0, 4, 0, a);
    lb(0, a,     B_CS,   0, "n4_cs_first");
    lb(0, a + 6, B_CS,   0, "n4_cs_last_low");
    lb(0, a + 1, B_CK,   0, "n4_ck_setup");
    lb(0, a + 2, B_CK,   1, "n4_ck_first");
    lb(0, a + 5, B_LAST, 1, "n4_cyc_last");
    lb(0, a + 6, B_CK,   0, "n4_ck_hold");
    lb(0, a + 7, B_DONE, 1, "n4_done");
    lb(0, a + 7, B_ABT,  0, "n4_aborted");
    lb(0, a + 7, B_CS,   1, "n4_cs_release");
    lb(0, a + 8, B_RDY,  0, "n4_ready_recover");
    lb(0, a + 9, B_RDY,  1, "n4_ready_again");
    lc(0, a, a + 9, 4, "n4_ck_count");

    // N = 0 (request held during previous recovery)
    do_req(0, 0, 0, a);
    lb(0, a + 2, B_CS,   0, "n0_cs_low3");
    lb(0, a + 3, B_DONE, 1, "n0_done");
    lb(0, a + 3, B_ABT,  0, "n0_aborted");
    lc(0, a, a + 5, 0, "n0_ck_count");

    // N = 8, abort on 3rd CK cycle
    do_req(0, 8, S + 3, a);
    lb(0, a + 5, B_CK,   0, "ab3_ck_off");
    lb(0, a + 5, B_CS,   0, "ab3_hold");
    lb(0, a + 6, B_DONE, 1, "ab3_done");
    lb(0, a + 6, B_ABT,  1, "ab3_aborted");
    lc(0, a, a + 8, 3, "ab3_ck_count");
    pulse_abort(0, a, S + 3);

    // N = 8, abort coincident with last CK cycle
    do_req(0, 8, S + 8, a);
    lb(0, a + 9,  B_LAST, 1, "ab8_cyc_last");
    lb(0, a + 11, B_DONE, 1, "ab8_done");
    lb(0, a + 11, B_ABT,  0, "ab8_aborted");
    lc(0, a, a + 13, 8, "ab8_ck_count");
    pulse_abort(0, a, S + 8);

    // back-to-back N = 1 with valid held
    do_req(0, 1, 0, a1);
    do_req(0, 1, 0, a2);
    do_req(0, 1, 0, a3);
    do_req(0, 1, 0, a4);
    lb(0, a1 + 3, B_CS, 0, "b2b_hold");
    lb(0, a1 + 4, B_CS, 1, "b2b_gap1");
    lb(0, a1 + 6, B_CS, 1, "b2b_gap3");
    lb(0, a1 + 7, B_CS, 0, "b2b_next_low");
    lc(0, a1, a4 + 6, 4, "b2b_ck_count");

    // reset in the 50th CK cycle of N = 100
    do_req(0, 100, 0, a);
    x = a + S + 49;
    lc(0, a, x, 49, "rst_ck_count");
    wait_to(x);
    rst = 1'b1;
    for (int c = x; c < DEPTH; c++) exp_v[0][c] = IDLE_V;
    lb(0, x,     B_CS,   1, "rst_cs_async");
    lb(0, x,     B_CK,   0, "rst_ck_async");
    lb(0, x + 1, B_DONE, 0, "rst_no_done");
    wait_to(x + 2);
    rst = 1'b0;
    m_free[0] = x + 2;
    do_req(0, 2, 0, a);
    lb(0, a + 5, B_DONE, 1, "post_rst_done");
    lb(0, a + 5, B_ABT,  0, "post_rst_aborted");
    lc(0, a, a + 7, 2, "post_rst_ck_count");

    // CNT_W = 4, full-scale N = 15
    do_req(1, 15, 0, a);
    lb(1, a + 16, B_LAST, 1, "n15_cyc_last");
    lb(1, a + 17, B_CS,   0, "n15_hold");
    lb(1, a + 18, B_DONE, 1, "n15_done");
    lc(1, a, a + 20, 15, "n15_ck_count");

    wait_to(((m_free[0] > m_free[1]) ? m_free[0] : m_free[1]) + 6);
    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
